gate_vector_sequencer: RTL and testbench

Hardware stimulus controller for small combinational gate datapaths (AND/OR/XOR-class primitives). On a start pulse it sweeps every input combination into the attached gate, waits a programmable settle time, and checks the gate output against an expected truth table. It reports done, pass/fail, mismatch count and the first failing vector. It sits beside the gate under test and replaces hand-written vector lists in lab-board and self-checking simulation flows.

---
 rtl/gate_vector_sequencer_pkg.sv | 12 +
 rtl/gate_vector_sequencer_if.sv | 13 +
 rtl/gate_vector_sequencer_settle_timer.sv | 16 +
 rtl/gate_vector_sequencer.sv | 81 ++++++++
 tb/tb_gate_vector_sequencer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/gate_vector_sequencer_pkg.sv
// gate_seq_pkg: shared state encoding, limits and standard truth tables for the gate vector sequencer
package gate_seq_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, APPLY = 3'd1, WAIT = 3'd2, CHECK = 3'd3, DONE = 3'd4} state_t;
  localparam int MAX_N_IN = 6;
  localparam int MAX_SETTLE = 15;
  localparam logic [3:0] TRUTH_AND2 = 4'b1000;
  localparam logic [3:0] TRUTH_OR2 = 4'b1110;
  localparam logic [3:0] TRUTH_XOR2 = 4'b0110;
  function automatic logic [3:0] settle_load(input int s);
    return 4'(s > 0 ? s - 1 : 0);
  endfunction
endpackage

// File: rtl/gate_vector_sequencer_if.sv
// gate_vector_sequencer_if: stimulus/result bundle between sequencer (slave) and its driver/gate side (master)
interface gate_vector_sequencer_if #(parameter int N_IN = 2);
  logic start;
  logic dut_out;
  logic [N_IN-1:0] dut_in;
  logic busy;
  logic done;
  logic pass;
  logic [N_IN:0] err_count;
  logic [N_IN-1:0] first_fail;
  modport master (output start, dut_out, input dut_in, busy, done, pass, err_count, first_fail);
  modport slave (input start, dut_out, output dut_in, busy, done, pass, err_count, first_fail);
endinterface

// File: rtl/gate_vector_sequencer_settle_timer.sv
// settle_timer: loadable down-counter whose expire flag marks the last settle cycle
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_en,
  input  logic [3:0] i_val,
  output logic       o_expire
);
  logic [3:0] r_cnt;
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_en && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
  assign o_expire = r_cnt == 4'd0;
endmodule

// File: rtl/gate_vector_sequencer.sv
// gate_vector_sequencer: sweeps all input vectors into a gate and checks it; GATE_SEQ_STOP_ON_FAIL_EN ends on first mismatch
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0] TRUTH = TRUTH_AND2
) (
  input logic clk,
  input logic rst,
  gate_vector_sequencer_if.slave bus
);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  state_t r_state;
  logic [N_IN-1:0] r_vec, r_dut_in, r_first;
  logic [N_IN:0] r_err;
  logic r_busy, r_done, r_pass;
  logic w_expire, w_miss, w_fin;
  settle_timer u_timer (
    .clk(clk), .rst(rst), .i_load(r_state == APPLY), .i_en(r_state == WAIT),
    .i_val(settle_load(SETTLE)), .o_expire(w_expire)
  );
  assign w_miss = bus.dut_out != TRUTH[r_vec];
  assign w_fin = (&r_vec) || (STOP && w_miss);
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_vec <= '0;
      r_dut_in <= '0;
      r_first <= '0;
      r_err <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_state <= APPLY;
          r_busy <= 1'b1;
          r_vec <= '0;
          r_err <= '0;
          r_first <= '0;
        end
        APPLY: begin
          r_dut_in <= r_vec;
          r_state <= SETTLE > 0 ? WAIT : CHECK;
        end
        WAIT: if (w_expire) r_state <= CHECK;
        CHECK: begin
          if (w_miss) begin
            r_err <= r_err + (N_IN+1)'(1);
            if (r_err == '0) r_first <= r_vec;
          end
          if (w_fin) begin
            r_state <= DONE;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_vec <= r_vec + N_IN'(1);
            r_state <= APPLY;
          end
        end
        DONE: begin
          r_pass <= r_err == '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign bus.dut_in = r_dut_in;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.pass = r_pass;
  assign bus.err_count = r_err;
  assign bus.first_fail = r_first;
endmodule

// File: tb/tb_gate_vector_sequencer.sv
// tb_gate_vector_sequencer: randomized gate tables against a truth-table reference model on two sequencer configs
module tb_gate_vector_sequencer;
  import gate_seq_pkg::*;
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] tbl_a = TRUTH_AND2;
  logic [7:0] tbl_b = 8'h80;
  gate_vector_sequencer_if #(.N_IN(2)) ifa ();
  gate_vector_sequencer_if #(.N_IN(3)) ifb ();
  assign ifa.dut_out = tbl_a[ifa.dut_in];
  assign ifb.dut_out = tbl_b[ifb.dut_in];
  gate_vector_sequencer #(.N_IN(2), .SETTLE(1), .TRUTH(TRUTH_AND2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  gate_vector_sequencer #(.N_IN(3), .SETTLE(0), .TRUTH(8'h80)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  bit sel;
  logic done_s, busy_s, pass_s;
  logic [2:0] din_s, first_s;
  logic [3:0] err_s;
  assign done_s = sel ? ifb.done : ifa.done;
  assign busy_s = sel ? ifb.busy : ifa.busy;
  assign pass_s = sel ? ifb.pass : ifa.pass;
  assign din_s = sel ? ifb.dut_in : {1'b0, ifa.dut_in};
  assign first_s = sel ? ifb.first_fail : {1'b0, ifa.first_fail};
  assign err_s = sel ? ifb.err_count : {1'b0, ifa.err_count};
  int n_vec = 0;
  int n_bad = 0;

  task automatic set_start(input bit v);
    if (sel) ifb.start = v;
    else ifa.start = v;
  endtask

  task automatic watch(input string name, input int s, input int napp, input int exp_done,
                       input int nmis, input int first, input bit mid);
    int dc = -1;
    int nbusy = 0;
    for (int k = 1; k <= 100 && dc < 0; k++) begin
      @(negedge clk);
      if (k >= 2 && (k - 2) % (s + 2) == 0 && (k - 2) / (s + 2) < napp) begin
        n_vec++;
        if (din_s !== 3'((k - 2) / (s + 2))) begin
          n_bad++;
          $display("FAIL %s dut_in cycle %0d got %0d exp %0d", name, k, din_s, (k - 2) / (s + 2));
        end
      end
      nbusy += int'(busy_s);
      if (done_s) dc = k;
      if (mid && k == 4) set_start(1'b1);
      if (mid && k == 5) set_start(1'b0);
    end
    n_vec++;
    if (dc != exp_done) begin
      n_bad++;
      $display("FAIL %s done_cycle got %0d exp %0d", name, dc, exp_done);
    end
    n_vec++;
    if (nbusy != exp_done - 1) begin
      n_bad++;
      $display("FAIL %s busy_cycles got %0d exp %0d", name, nbusy, exp_done - 1);
    end
    n_vec++;
    if (err_s !== 4'(nmis)) begin
      n_bad++;
      $display("FAIL %s err_count got %0d exp %0d", name, err_s, nmis);
    end
    n_vec++;
    if (first_s !== 3'(first < 0 ? 0 : first)) begin
      n_bad++;
      $display("FAIL %s first_fail got %0d exp %0d", name, first_s, first < 0 ? 0 : first);
    end
  endtask

  task automatic check_after(input string name, input int nmis);
    @(negedge clk);
    n_vec++;
    if (pass_s !== (nmis == 0)) begin
      n_bad++;
      $display("FAIL %s pass got %0b exp %0b", name, pass_s, nmis == 0);
    end
    n_vec++;
    if (busy_s !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy_after_done got %0b exp 0", name, busy_s);
    end
  endtask

  task automatic run_sweep(input string name, input bit b, input logic [7:0] tbl, input bit mid, input bit hold);
    int s = b ? 0 : 1;
    int nv = b ? 8 : 4;
    logic [7:0] truth = b ? 8'h80 : {4'h0, TRUTH_AND2};
    int nmis = 0;
    int first = -1;
    int napp;
    int exp_done;
    sel = b;
    if (b) tbl_b = tbl;
    else tbl_a = tbl[3:0];
    for (int v = 0; v < nv; v++)
      if (tbl[v] !== truth[v]) begin
        if (first < 0) first = v;
        nmis++;
      end
    if (STOP && nmis > 0) nmis = 1;
    napp = (STOP && first >= 0) ? first + 1 : nv;
    exp_done = napp * (s + 2) + 1;
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    #1 if (!hold) set_start(1'b0);
    watch(name, s, napp, exp_done, nmis, first, mid);
    check_after(name, nmis);
    if (hold) begin
      @(posedge clk);
      #1 set_start(1'b0);
      watch({name, "_second"}, s, napp, exp_done, nmis, first, 1'b0);
      check_after({name, "_second"}, nmis);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({ifa.busy, ifa.done, ifa.pass, ifa.dut_in, ifa.err_count, ifa.first_fail} !== '0) begin
      n_bad++;
      $display("FAIL reset_a got %b exp 0", {ifa.busy, ifa.done, ifa.pass, ifa.dut_in, ifa.err_count, ifa.first_fail});
    end
    n_vec++;
    if ({ifb.busy, ifb.done, ifb.pass, ifb.dut_in, ifb.err_count, ifb.first_fail} !== '0) begin
      n_bad++;
      $display("FAIL reset_b got %b exp 0", {ifb.busy, ifb.done, ifb.pass, ifb.dut_in, ifb.err_count, ifb.first_fail});
    end
    rst = 1'b0;
  endtask

  task automatic test_mid_reset();
    run_sweep("pre_reset_and2", 1'b0, 8'h08, 1'b0, 1'b0);
    @(negedge clk);
    ifa.start = 1'b1;
    @(posedge clk);
    #1 ifa.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({ifa.busy, ifa.done, ifa.pass, ifa.dut_in, ifa.err_count} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset got %b exp 0", {ifa.busy, ifa.done, ifa.pass, ifa.dut_in, ifa.err_count});
    end
    run_sweep("post_reset_and2", 1'b0, 8'h08, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      bit b = 1'($urandom_range(0, 1));
      logic [7:0] t = 8'($urandom);
      run_sweep($sformatf("random_%0d", i), b, t, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    test_reset();
    run_sweep("and2", 1'b0, {4'h0, TRUTH_AND2}, 1'b0, 1'b0);
    run_sweep("stuck1", 1'b0, 8'h0F, 1'b0, 1'b0);
    run_sweep("xor_vs_and", 1'b0, {4'h0, TRUTH_XOR2}, 1'b0, 1'b0);
    run_sweep("or_vs_and", 1'b0, {4'h0, TRUTH_OR2}, 1'b0, 1'b0);
    test_mid_reset();
    run_sweep("start_during_busy", 1'b0, {4'h0, TRUTH_AND2}, 1'b1, 1'b0);
    run_sweep("start_held", 1'b0, 8'h0F, 1'b0, 1'b1);
    run_sweep("and3_settle0", 1'b1, 8'h80, 1'b0, 1'b0);
    run_sweep("and3_stuck1", 1'b1, 8'hFF, 1'b0, 1'b0);
    run_sweep("and3_back_to_back", 1'b1, 8'h80, 1'b0, 1'b1);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
